// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two valid/ready requesters.
// Two-stage path: issue register drives the ALU, result lands in a per-requester response buffer.
module alu_arbiter #(
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [DW-1:0] req0_opa,
    input  logic [DW-1:0] req0_opb,
    input  logic [3:0]    req0_ctrl,

    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [DW-1:0] req1_opa,
    input  logic [DW-1:0] req1_opb,
    input  logic [3:0]    req1_ctrl,

    output logic [DW-1:0] alu_opa,
    output logic [DW-1:0] alu_opb,
    output logic [3:0]    alu_ctrl,
    input  logic [DW-1:0] alu_out,
    input  logic          alu_less,
    input  logic          alu_zero,

    output logic          rsp0_valid,
    input  logic          rsp0_ready,
    output logic [DW-1:0] rsp0_data,
    output logic          rsp0_less,
    output logic          rsp0_zero,

    output logic          rsp1_valid,
    input  logic          rsp1_ready,
    output logic [DW-1:0] rsp1_data,
    output logic          rsp1_less,
    output logic          rsp1_zero,

    output logic          busy
);

    logic          r_is_valid;
    logic          r_is_id;
    logic          r_last;
    logic [DW-1:0] r_is_opa;
    logic [DW-1:0] r_is_opb;
    logic [3:0]    r_is_ctrl;

    logic [1:0]    r_rb_valid;
    logic [1:0]    r_rb_less;
    logic [1:0]    r_rb_zero;
    logic [DW-1:0] r_rb_data [2];

    logic [1:0]    w_rsp_ready;
    logic          w_is_adv;
    logic          w_acc_en;
    logic          w_grant;
    logic          w_accept;
    logic [DW-1:0] w_sel_opa;
    logic [DW-1:0] w_sel_opb;
    logic [3:0]    w_sel_ctrl;

    assign w_rsp_ready = {rsp1_ready, rsp0_ready};
    // Issue only leaves when its destination buffer is free or draining this cycle.
    assign w_is_adv    = r_is_valid && (!r_rb_valid[r_is_id] || w_rsp_ready[r_is_id]);
    assign w_acc_en    = !r_is_valid || w_is_adv;
    assign w_accept    = w_acc_en && (req0_valid || req1_valid);

    // Round-robin: on contention the requester not served last wins.
    always_comb begin
        w_grant = 1'b0;
        if (req0_valid && req1_valid) begin
            w_grant = !r_last;
        end else if (req1_valid) begin
            w_grant = 1'b1;
        end
    end

    assign w_sel_opa  = w_grant ? req1_opa  : req0_opa;
    assign w_sel_opb  = w_grant ? req1_opb  : req0_opb;
    assign w_sel_ctrl = w_grant ? req1_ctrl : req0_ctrl;

    assign req0_ready = w_acc_en && req0_valid && !w_grant;
    assign req1_ready = w_acc_en && req1_valid &&  w_grant;

    // Issue stage; operand registers hold their values when the stage empties.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_is_valid <= 1'b0;
            r_is_id    <= 1'b0;
            r_last     <= 1'b1;
            r_is_opa   <= '0;
            r_is_opb   <= '0;
            r_is_ctrl  <= '0;
        end else if (w_accept) begin
            r_is_valid <= 1'b1;
            r_is_id    <= w_grant;
            r_last     <= w_grant;
            r_is_opa   <= w_sel_opa;
            r_is_opb   <= w_sel_opb;
            r_is_ctrl  <= w_sel_ctrl;
        end else if (w_is_adv) begin
            r_is_valid <= 1'b0;
        end
    end

    // Response buffers: a refill in the same cycle as a drain keeps the entry valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rb_valid <= '0;
            r_rb_less  <= '0;
            r_rb_zero  <= '0;
            for (int i = 0; i < 2; i++) begin
                r_rb_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (w_is_adv && (r_is_id == 1'(i))) begin
                    r_rb_valid[i] <= 1'b1;
                    r_rb_data[i]  <= alu_out;
                    r_rb_less[i]  <= alu_less;
                    r_rb_zero[i]  <= alu_zero;
                end else if (r_rb_valid[i] && w_rsp_ready[i]) begin
                    r_rb_valid[i] <= 1'b0;
                end
            end
        end
    end

    assign alu_opa    = r_is_opa;
    assign alu_opb    = r_is_opb;
    assign alu_ctrl   = r_is_ctrl;

    assign rsp0_valid = r_rb_valid[0];
    assign rsp0_data  = r_rb_data[0];
    assign rsp0_less  = r_rb_less[0];
    assign rsp0_zero  = r_rb_zero[0];

    assign rsp1_valid = r_rb_valid[1];
    assign rsp1_data  = r_rb_data[1];
    assign rsp1_less  = r_rb_less[1];
    assign rsp1_zero  = r_rb_zero[1];

    assign busy = r_is_valid | r_rb_valid[0] | r_rb_valid[1];

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-port arbiter that shares a single `alu` instance between two requesters, such as the integer pipe and a multi-cycle sequencer. It uses a valid/ready handshake on each side. The block registers the granted operation into an issue stage that drives the ALU operand and control inputs. It then captures the ALU result into a per-requester response buffer, giving a 2-stage, fully pipelined path with round-robin fairness.

## Interface
- `DW`, 32, operand/result width (must match the shared ALU)
- `clk`  in  1  clock; all state updates on the rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `reqN_valid`  in  1  requester N (N=0,1) offers an operation
- `reqN_ready`  out  1  requester N's operation is accepted this cycle
- `reqN_opa`, `reqN_opb`  in  DW  operands
- `reqN_ctrl`  in  4  ALU control code, passed through unmodified
- `alu_opa`, `alu_opb`  out  DW  registered operands to the ALU
- `alu_ctrl`  out  4  registered control to the ALU
- `alu_out`  in  DW  ALU result (combinational from `alu_*` outputs)
- `alu_less`, `alu_zero`  in  1  ALU flags
- `rspN_valid`  out  1  response for requester N is held
- `rspN_ready`  in  1  requester N consumes the response
- `rspN_data`  out  DW  captured `alu_out`
- `rspN_less`, `rspN_zero`  out  1  captured flags
- `busy`  out  1  issue stage or any response buffer occupied

## Operation
- **Issue stage (IS)** has fields `is_valid`, `is_id` (0/1), opa, opb and ctrl. Its register contents drive `alu_opa`, `alu_opb` and `alu_ctrl` directly.
- **Response buffers** RB0 and RB1 are one entry each, holding valid, data, less and zero.
- **Advance:** `is_adv = is_valid && (!rb_valid[is_id] || rsp_ready[is_id])`.
  - On advance, `alu_out`, `alu_less` and `alu_zero` are written into RB[is_id], whose valid is set.
- **Drain:** RB[i].valid clears on `rspi_valid && rspi_ready`, unless a simultaneous advance refills it.
- **Accept enable:** `acc_en = !is_valid || is_adv`.
- **Grant:** combinational round-robin among valid requesters, using pointer `last` (the id of the most recent acceptance).
  - Both requests valid: grant `!last`.
  - One request valid: grant that requester.
  - `reqN_ready = acc_en && grant==N`. Readiness depends on `reqN_valid`.
- **Accept:** on acceptance, IS loads the granted request's fields and `is_id`, and `last` updates. If nothing is accepted while `is_adv` is true, `is_valid` clears. Otherwise IS holds.
- **Head-of-line blocking is required behaviour.** A stalled RB[is_id] stalls IS, so the other requester's ready stays low even if its RB is empty.
- **Operand registers** keep their last values when IS empties. They are not zeroed.
- `busy = is_valid | rb_valid[0] | rb_valid[1]`.

## Timing
- **Reset values:**
  - `is_valid` = 0; `alu_opa`, `alu_opb`, `alu_ctrl` = 0.
  - `rspN_valid` = 0; `rspN_data`, `rspN_less`, `rspN_zero` = 0.
  - `last` = 1, so req0 wins the first contention.
  - `busy` = 0. `reqN_ready` = `reqN_valid` after reset.
- **Latency:** a request accepted at edge k appears on `alu_*` after edge k. Its response is valid after edge k+1, i.e. 2 cycles from `valid` to `rsp_valid`.
- **Throughput:** 1 operation per cycle when responses are consumed every cycle. Back-to-back contention alternates 0,1,0,1.
- **Simultaneous drain and refill** of the same RB in one cycle: RB stays valid with the new data, so there is no bubble.
- **Reset mid-operation:** asynchronous clear. In-flight operations are discarded and no response is produced for them.
- Request fields must stay stable while `valid && !ready`. Response fields are stable while `rsp_valid && !rsp_ready`.

## Test plan
The bench uses an ALU stub: `alu_out = opa ^ opb`, `less = opa < opb` (unsigned), `zero = (out == 0)`.
- **Single request:** after reset, req0 sends opa=0x0F, opb=0xF0 with rsp0_ready=1. Required: ready the same cycle, `rsp0_valid` 2 cycles later, data 0xFF, less=1, zero=0, then `busy` falls.
- **Contention:** both requesters valid continuously with distinct operands. Required grant order 0,1,0,1, one response per cycle, each response routed to the correct rspN.
- **Backpressure:** rsp0_ready=0 while req0 issues 3 operations. Required:
  - first result held in RB0;
  - second held in IS with `alu_*` stable;
  - req0_ready and req1_ready low (head-of-line block).
  - After rsp0_ready=1, results drain in order with no loss.
- **Zero flag plus refill:** opa=opb=0x1234 gives data 0, zero=1. Next, drain and refill RB1 in the same cycle; required: `rsp1_valid` stays high and the data changes on that edge.
- **Mid-operation reset:** assert rst_n=0 for 1 cycle with IS and both RBs full. Required: all valids drop immediately (asynchronous), no stale responses, and req0 wins the next contention.
